// File: rtl/mem_stage.sv
// Memory-access stage: branch resolve, req/ack data-memory FSM with stall, MEM/WB register.
// Optional build macro MEM_TIMEOUT_EN aborts an ACCESS after TIMEOUT cycles and flags MemErr.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        En,
  input  logic        Clr,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic [31:0] JumpAddr_i,
  input  logic [31:0] Result_i,
  input  logic        Zero_i,
  input  logic [31:0] rData2_i,
  input  logic [4:0]  wAddr_i,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        Stall,
  output logic        PCSrc,
  output logic [31:0] BranchAddr,
  output logic [31:0] ReadData,
  output logic [31:0] ALUResult,
  output logic [4:0]  wAddr,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        MemErr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  if (TIMEOUT < 2) begin : gTimeoutCheck
    $error("mem_stage: TIMEOUT must be at least 2");
  end

  logic [1:0]  state, nextState;
  logic [31:0] holdData;
  logic        killed;
  logic        memOp;
  logic        expired;
  logic        errNow;
  logic        loadEn;
  logic        bubble;

  assign memOp      = MemRead | MemWrite;
  assign dm_req     = (state == ACCESS);
  assign dm_we      = MemWrite;
  assign dm_addr    = {Result_i[31:2], 2'b00};
  assign dm_wdata   = rData2_i;
  assign PCSrc      = Branch & Zero_i & (state == IDLE);
  assign BranchAddr = JumpAddr_i;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] toCnt;
  logic          pendErr;

  assign expired = (state == ACCESS) && !dm_ack && (toCnt == CW'(TIMEOUT - 1));
  assign errNow  = (state == DONE) && pendErr;

  always_ff @(posedge clk) begin
    if (rst) begin
      toCnt   <= '0;
      pendErr <= 1'b0;
    end else if (state == IDLE && memOp) begin
      toCnt   <= '0;
      pendErr <= 1'b0;
    end else if (state == ACCESS && !dm_ack) begin
      toCnt <= toCnt + 1'b1;
      if (expired) pendErr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         MemErr <= 1'b0;
    else if (loadEn) MemErr <= !bubble && errNow;
  end
`else
  assign expired = 1'b0;
  assign errNow  = 1'b0;
  assign MemErr  = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    nextState = state;
    Stall     = 1'b0;
    case (state)
      IDLE: if (memOp) begin
        nextState = ACCESS;
        Stall     = 1'b1;
      end
      ACCESS: begin
        Stall = 1'b1;
        if (dm_ack || expired) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      holdData <= '0;
      killed   <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        // Hold data starts at 0, so stores and aborted accesses hand 0 to write-back.
        IDLE: if (memOp) begin
          holdData <= '0;
          killed   <= Clr;
        end
        ACCESS: begin
          if (Clr) killed <= 1'b1;
          if (dm_ack) holdData <= MemWrite ? 32'h0 : dm_rdata;
        end
        default: ;
      endcase
    end
  end

  // A flush seen while the transaction was in flight turns its DONE slot into a bubble.
  assign loadEn = En && !Stall;
  assign bubble = Clr || ((state == DONE) && killed);

  always_ff @(posedge clk) begin
    if (rst) begin
      ReadData  <= '0;
      ALUResult <= '0;
      wAddr     <= '0;
      RegWrite  <= 1'b0;
      MemtoReg  <= 1'b0;
    end else if (loadEn) begin
      if (bubble) begin
        ReadData  <= '0;
        ALUResult <= '0;
        wAddr     <= '0;
        RegWrite  <= 1'b0;
        MemtoReg  <= 1'b0;
      end else begin
        ReadData  <= (state == DONE) ? holdData : 32'h0;
        ALUResult <= Result_i;
        wAddr     <= wAddr_i;
        RegWrite  <= RegWrite_i && !errNow;
        MemtoReg  <= MemtoReg_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (TIMEOUT=4); the timeout scenario depends on MEM_TIMEOUT_EN.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst, En, Clr, Branch, MemRead, MemWrite, RegWrite_i, MemtoReg_i, Zero_i, dm_ack;
  logic [31:0] JumpAddr_i, Result_i, rData2_i, dm_rdata;
  logic [4:0]  wAddr_i;
  logic        dm_req, dm_we, Stall, PCSrc, RegWrite, MemtoReg, MemErr;
  logic [31:0] dm_addr, dm_wdata, BranchAddr, ReadData, ALUResult;
  logic [4:0]  wAddr;

  int nChecks = 0;
  int nFails  = 0;
  int sCnt, rCnt, wCnt;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .En(En), .Clr(Clr), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .JumpAddr_i(JumpAddr_i), .Result_i(Result_i), .Zero_i(Zero_i), .rData2_i(rData2_i),
    .wAddr_i(wAddr_i), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .Stall(Stall), .PCSrc(PCSrc), .BranchAddr(BranchAddr),
    .ReadData(ReadData), .ALUResult(ALUResult), .wAddr(wAddr), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .MemErr(MemErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic setNop;
    MemRead = 0; MemWrite = 0; Branch = 0; Clr = 0; dm_ack = 0;
    RegWrite_i = 0; MemtoReg_i = 0;
  endtask

  // Runs one memory op already presented in IDLE until its DONE slot has loaded MEM/WB.
  // ackCycle/clrCycle are 1-based ACCESS cycle numbers (0 = never).
  task automatic runAccess(input int ackCycle, input int clrCycle, input int budget,
                           output int stallCnt, output int reqCnt, output int weCnt);
    int  accIdx;
    bit  stalled, finished;
    stallCnt = 0; reqCnt = 0; weCnt = 0; accIdx = 0; stalled = 0; finished = 0;
    for (int c = 0; c < budget && !finished; c++) begin
      #1;
      if (Stall) begin
        stallCnt++;
        stalled = 1;
      end else if (stalled) begin
        finished = 1;
      end
      if (dm_req) begin
        reqCnt++;
        accIdx++;
        if (dm_we) weCnt++;
      end
      dm_ack = dm_req && (accIdx == ackCycle);
      Clr    = dm_req && (accIdx == clrCycle);
      @(posedge clk);
      #1;
      dm_ack = 0;
      Clr    = 0;
    end
    if (!finished) check("access_budget_expired", 32'd0, 32'd1);
    setNop;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; En = 1; setNop;
    Zero_i = 0; JumpAddr_i = 0; Result_i = 0; rData2_i = 0; wAddr_i = 0; dm_rdata = 0;
    repeat (2) nextCycle;
    check("reset_ReadData", ReadData, 0);
    check("reset_ALUResult", ALUResult, 0);
    check("reset_wAddr", wAddr, 0);
    check("reset_RegWrite", RegWrite, 0);
    check("reset_MemtoReg", MemtoReg, 0);
    check("reset_MemErr", MemErr, 0);
    check("reset_dm_req", dm_req, 0);
    rst = 0;
    nextCycle;

    // Load, ack on first ACCESS cycle
    MemRead = 1; Result_i = 32'h0000_0103; wAddr_i = 5; RegWrite_i = 1; MemtoReg_i = 1;
    dm_rdata = 32'hDEAD_BEEF;
    #1;
    check("t1_dm_addr", dm_addr, 32'h0000_0100);
    check("t1_dm_we", dm_we, 0);
    check("t1_pcsrc_nobranch", PCSrc, 0);
    runAccess(1, 0, 20, sCnt, rCnt, wCnt);
    check("t1_stall_cycles", sCnt, 2);
    check("t1_req_cycles", rCnt, 1);
    check("t1_ReadData", ReadData, 32'hDEAD_BEEF);
    check("t1_wAddr", wAddr, 5);
    check("t1_RegWrite", RegWrite, 1);
    check("t1_MemtoReg", MemtoReg, 1);
    check("t1_ALUResult", ALUResult, 32'h0000_0103);

    // Store, ack on the 4th ACCESS cycle
    MemWrite = 1; Result_i = 32'h0000_2006; rData2_i = 32'h1234_5678; wAddr_i = 0;
    dm_rdata = 32'hCAFE_F00D;
    #1;
    check("t2_dm_wdata", dm_wdata, 32'h1234_5678);
    check("t2_dm_addr", dm_addr, 32'h0000_2004);
    runAccess(4, 0, 20, sCnt, rCnt, wCnt);
    check("t2_stall_cycles", sCnt, 5);
    check("t2_req_cycles", rCnt, 4);
    check("t2_we_cycles", wCnt, 4);
    check("t2_RegWrite", RegWrite, 0);
    check("t2_ReadData", ReadData, 0);
    check("t2_ALUResult", ALUResult, 32'h0000_2006);

    // Branch taken / not taken, then branch alongside a load
    Branch = 1; Zero_i = 1; JumpAddr_i = 32'h0000_0040;
    #1;
    check("t3_pcsrc_taken", PCSrc, 1);
    check("t3_branch_addr", BranchAddr, 32'h0000_0040);
    Zero_i = 0;
    #1;
    check("t3_pcsrc_zero0", PCSrc, 0);
    Zero_i = 1; MemRead = 1; RegWrite_i = 1; Result_i = 32'h0000_0010; wAddr_i = 2;
    dm_rdata = 32'h0BAD_F00D;
    #1;
    check("t3_pcsrc_idle", PCSrc, 1);
    nextCycle;
    check("t3_pcsrc_access", PCSrc, 0);
    check("t3_req_access", dm_req, 1);
    dm_ack = 1;
    nextCycle;
    dm_ack = 0;
    check("t3_pcsrc_done", PCSrc, 0);
    nextCycle;
    setNop;
    Zero_i = 0;
    check("t3_ReadData", ReadData, 32'h0BAD_F00D);
    check("t3_RegWrite", RegWrite, 1);

    // MemRead and MemWrite together behave as a store
    MemRead = 1; MemWrite = 1; RegWrite_i = 1; Result_i = 32'h0000_0300; wAddr_i = 6;
    dm_rdata = 32'h1111_2222;
    #1;
    check("rw_dm_we", dm_we, 1);
    runAccess(1, 0, 20, sCnt, rCnt, wCnt);
    check("rw_ReadData", ReadData, 0);
    check("rw_RegWrite", RegWrite, 1);

    // Clr during ACCESS kills the write-back of the load
    MemRead = 1; RegWrite_i = 1; MemtoReg_i = 1; Result_i = 32'h0000_0200; wAddr_i = 7;
    dm_rdata = 32'hA5A5_A5A5;
    runAccess(3, 2, 20, sCnt, rCnt, wCnt);
    check("t4_stall_cycles", sCnt, 4);
    check("t4_req_cycles", rCnt, 3);
    check("t4_RegWrite", RegWrite, 0);
    check("t4_ReadData", ReadData, 0);
    check("t4_wAddr", wAddr, 0);

    // En/Clr interaction on plain ALU instructions
    RegWrite_i = 1; Result_i = 32'h0000_0055; wAddr_i = 9;
    nextCycle;
    check("en_load_ALUResult", ALUResult, 32'h0000_0055);
    check("en_load_RegWrite", RegWrite, 1);
    En = 0; Clr = 1; Result_i = 32'h0000_0066;
    nextCycle;
    check("hold_ALUResult", ALUResult, 32'h0000_0055);
    check("hold_RegWrite", RegWrite, 1);
    En = 1;
    nextCycle;
    check("clr_RegWrite", RegWrite, 0);
    check("clr_ALUResult", ALUResult, 0);
    Clr = 0;

    // dm_ack while idle is ignored
    dm_ack = 1;
    nextCycle;
    dm_ack = 0;
    check("stray_ack_req", dm_req, 0);
    check("stray_ack_stall", Stall, 0);

    // Reset during ACCESS, late ack afterwards
    RegWrite_i = 1; Result_i = 32'h0000_0077; wAddr_i = 3;
    nextCycle;
    MemRead = 1; dm_rdata = 32'hFFFF_0000;
    nextCycle;
    check("t5_req_before_rst", dm_req, 1);
    rst = 1;
    nextCycle;
    rst = 0; setNop; Result_i = 0; wAddr_i = 0; dm_ack = 1;
    #1;
    check("t5_req_after_rst", dm_req, 0);
    check("t5_ALUResult", ALUResult, 0);
    check("t5_RegWrite", RegWrite, 0);
    check("t5_wAddr", wAddr, 0);
    nextCycle;
    dm_ack = 0;
    check("t5_late_ack_req", dm_req, 0);
    check("t5_late_ack_stall", Stall, 0);

    // Access that is never acknowledged (or acknowledged very late)
    MemRead = 1; RegWrite_i = 1; Result_i = 32'h0000_0400; wAddr_i = 4;
    dm_rdata = 32'h1357_9BDF;
`ifdef MEM_TIMEOUT_EN
    runAccess(0, 0, 20, sCnt, rCnt, wCnt);
    check("t6_req_cycles", rCnt, 4);
    check("t6_stall_cycles", sCnt, 5);
    check("t6_MemErr", MemErr, 1);
    check("t6_RegWrite", RegWrite, 0);
    check("t6_ReadData", ReadData, 0);
    check("t6_ALUResult", ALUResult, 32'h0000_0400);
    RegWrite_i = 1;
    nextCycle;
    check("t6_MemErr_clear", MemErr, 0);
    check("t6_RegWrite_next", RegWrite, 1);
`else
    runAccess(20, 0, 40, sCnt, rCnt, wCnt);
    check("t6_req_cycles", rCnt, 20);
    check("t6_stall_cycles", sCnt, 21);
    check("t6_MemErr", MemErr, 0);
    check("t6_RegWrite", RegWrite, 1);
    check("t6_ReadData", ReadData, 32'h1357_9BDF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
